int_isq: RTL and testbench

Integer issue queue sitting directly downstream of dispatch. Captures renamed micro-ops from dispatch together with their source busy state, and clears busy bits on writeback wakeups. Each cycle it selects the oldest fully-ready entry and presents it to the integer execution unit over a valid/ready handshake. Honours pipeline flush by dropping all contents.

---
 rtl/int_isq_pkg.sv | 29 ++
 rtl/int_isq_if.sv | 61 ++++++
 rtl/isq_age_sel.sv | 51 +++++
 rtl/int_isq.sv | 186 ++++++++++++++++++
 tb/tb_int_isq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/int_isq_pkg.sv
// Shared issue-queue package.
// Holds the register/ROB widths and default queue depth used by the integer
// issue queue. It also holds the payload packing order that dispatch and the
// execution unit use on the opaque micro-op payload bus.
package int_isq_pkg;

    // Physical register index width (matches `PREG_RANGE)
    localparam int unsigned ISQ_PREG_W    = 6;
    // ROB id width (matches `INSTR_ID_WIDTH)
    localparam int unsigned ISQ_ROBID_W   = 7;
    localparam int unsigned ISQ_DEPTH     = 8;
    localparam int unsigned ISQ_PAYLOAD_W = 256;
    localparam int unsigned ISQ_COUNT_W   = $clog2(ISQ_DEPTH) + 1;

    // Payload packing order, MSB first. The total is ISQ_PAYLOAD_W bits.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [3:0]  fu_type;
        logic [7:0]  op_type;
        logic [4:0]  lrd;
        logic [5:0]  prd;
        logic        pred_taken;
        logic [63:0] pred_target;
        logic [7:0]  rsvd;
    } isq_uop_t;

endpackage

// File: rtl/int_isq_if.sv
// Issue-queue bus interface.
// Carries three groups of signals: dispatch enqueue, writeback wakeup, and
// issue to the execution unit. It also carries flush and the occupancy count.
// Modports:
//   master - dispatch/exu/writeback side; drives enq, wb, issue_ready, flush
//   slave  - the issue queue; drives can_enq, issue outputs, count
interface int_isq_if
    import int_isq_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = ISQ_PAYLOAD_W,
    parameter int unsigned PREG_W    = ISQ_PREG_W,
    parameter int unsigned ROBID_W   = ISQ_ROBID_W,
    parameter int unsigned COUNT_W   = ISQ_COUNT_W
);
    logic                 disp2intisq_enq_valid;
    logic                 intisq_can_enq;
    logic [PAYLOAD_W-1:0] disp2intisq_enq_payload;
    logic [ROBID_W-1:0]   disp2intisq_enq_robid;
    logic [PREG_W-1:0]    disp2intisq_enq_prs1;
    logic [PREG_W-1:0]    disp2intisq_enq_prs2;
    logic                 disp2intisq_enq_src1_is_reg;
    logic                 disp2intisq_enq_src2_is_reg;
    logic                 disp2intisq_enq_src1_state;
    logic                 disp2intisq_enq_src2_state;
    logic                 wb0_valid;
    logic [PREG_W-1:0]    wb0_prd;
    logic                 wb1_valid;
    logic [PREG_W-1:0]    wb1_prd;
    logic                 intisq2exu_issue_valid;
    logic                 exu2intisq_issue_ready;
    logic [PAYLOAD_W-1:0] intisq2exu_issue_payload;
    logic [ROBID_W-1:0]   intisq2exu_issue_robid;
    logic [PREG_W-1:0]    intisq2exu_issue_prs1;
    logic [PREG_W-1:0]    intisq2exu_issue_prs2;
    logic [COUNT_W-1:0]   intisq_count;
    logic                 flush_valid;

    modport master (
        output disp2intisq_enq_valid, disp2intisq_enq_payload, disp2intisq_enq_robid,
               disp2intisq_enq_prs1, disp2intisq_enq_prs2,
               disp2intisq_enq_src1_is_reg, disp2intisq_enq_src2_is_reg,
               disp2intisq_enq_src1_state, disp2intisq_enq_src2_state,
               wb0_valid, wb0_prd, wb1_valid, wb1_prd,
               exu2intisq_issue_ready, flush_valid,
        input  intisq_can_enq, intisq2exu_issue_valid, intisq2exu_issue_payload,
               intisq2exu_issue_robid, intisq2exu_issue_prs1, intisq2exu_issue_prs2,
               intisq_count
    );

    modport slave (
        input  disp2intisq_enq_valid, disp2intisq_enq_payload, disp2intisq_enq_robid,
               disp2intisq_enq_prs1, disp2intisq_enq_prs2,
               disp2intisq_enq_src1_is_reg, disp2intisq_enq_src2_is_reg,
               disp2intisq_enq_src1_state, disp2intisq_enq_src2_state,
               wb0_valid, wb0_prd, wb1_valid, wb1_prd,
               exu2intisq_issue_ready, flush_valid,
        output intisq_can_enq, intisq2exu_issue_valid, intisq2exu_issue_payload,
               intisq2exu_issue_robid, intisq2exu_issue_prs1, intisq2exu_issue_prs2,
               intisq_count
    );
endinterface

// File: rtl/isq_age_sel.sv
// Age matrix and oldest-ready selector.
// In the age matrix, age[i][j] = 1 means entry j is older than entry i.
// Ports:
//   clock, reset - clock and async active-high reset
//   enq_fire     - an entry is written this cycle
//   enq_slot     - one-hot slot being written
//   valid        - current entry valid vector
//   ready        - entries eligible for issue
//   sel          - one-hot oldest ready entry (all zero if none ready)
module isq_age_sel #(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_fire,
    input  logic [DEPTH-1:0] enq_slot,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] sel
);
    logic [DEPTH-1:0] age [DEPTH];

    // A new entry is younger than every live entry. Its column is cleared
    // so that no older entry thinks it is older than a reused slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                age[k] <= '0;
            end
        end else if (enq_fire) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (enq_slot[k]) begin
                        age[k][j] <= valid[j];
                    end else if (enq_slot[j]) begin
                        age[k][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // Live entries form a total order, so at most one ready entry has no
    // older ready peer.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel[i] = ready[i] && ((age[i] & ready) == '0);
        end
    end
endmodule

// File: rtl/int_isq.sv
// Integer issue queue.
// Captures renamed micro-ops from dispatch, tracks the busy state of their
// source operands through writeback wakeups, and offers the oldest fully-ready
// entry to the integer execution unit over a valid/ready handshake. A flush
// drops all contents.
// Ports:
//   clock - sole clock
//   reset - asynchronous active-high reset
//   isq   - int_isq_if.slave: enqueue, wakeup, issue, flush and count
module int_isq
    import int_isq_pkg::*;
#(
    parameter int unsigned DEPTH     = ISQ_DEPTH,
    parameter int unsigned PAYLOAD_W = ISQ_PAYLOAD_W,
    parameter int unsigned PREG_W    = ISQ_PREG_W,
    parameter int unsigned ROBID_W   = ISQ_ROBID_W
) (
    input  logic     clock,
    input  logic     reset,
    int_isq_if.slave isq
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     is_reg1;
    logic [DEPTH-1:0]     is_reg2;
    logic [DEPTH-1:0]     busy1;
    logic [DEPTH-1:0]     busy2;
    logic [PAYLOAD_W-1:0] payload [DEPTH];
    logic [ROBID_W-1:0]   robid   [DEPTH];
    logic [PREG_W-1:0]    prs1    [DEPTH];
    logic [PREG_W-1:0]    prs2    [DEPTH];
    logic [CNT_W-1:0]     count;

    logic [DEPTH-1:0]     enq_slot;
    logic [DEPTH-1:0]     ready;
    logic [DEPTH-1:0]     sel;
    logic [DEPTH-1:0]     wake1;
    logic [DEPTH-1:0]     wake2;
    logic                 can_enq;
    logic                 enq_fire;
    logic                 issue_valid;
    logic                 issue_fire;
    logic                 enq_busy1;
    logic                 enq_busy2;

    logic [PAYLOAD_W-1:0] mux_payload;
    logic [ROBID_W-1:0]   mux_robid;
    logic [PREG_W-1:0]    mux_prs1;
    logic [PREG_W-1:0]    mux_prs2;

    function automatic logic wb_hit(
        input logic              v0,
        input logic [PREG_W-1:0] p0,
        input logic              v1,
        input logic [PREG_W-1:0] p1,
        input logic [PREG_W-1:0] prs
    );
        return (v0 && (p0 == prs)) || (v1 && (p1 == prs));
    endfunction

    // Lowest-index free slot
    always_comb begin
        logic taken;
        taken    = 1'b0;
        enq_slot = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!valid[i] && !taken) begin
                enq_slot[i] = 1'b1;
                taken       = 1'b1;
            end
        end
    end

    // A slot freed by issue this cycle is not reused until the next cycle
    assign can_enq  = !isq.flush_valid && (count != CNT_W'(DEPTH));
    assign enq_fire = isq.disp2intisq_enq_valid && can_enq;

    // A wakeup in the enqueue cycle is folded into the captured busy bit
    assign enq_busy1 = isq.disp2intisq_enq_src1_state && isq.disp2intisq_enq_src1_is_reg &&
                       !wb_hit(isq.wb0_valid, isq.wb0_prd, isq.wb1_valid, isq.wb1_prd,
                               isq.disp2intisq_enq_prs1);
    assign enq_busy2 = isq.disp2intisq_enq_src2_state && isq.disp2intisq_enq_src2_is_reg &&
                       !wb_hit(isq.wb0_valid, isq.wb0_prd, isq.wb1_valid, isq.wb1_prd,
                               isq.disp2intisq_enq_prs2);

    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wake1[i] = valid[i] && is_reg1[i] &&
                       wb_hit(isq.wb0_valid, isq.wb0_prd, isq.wb1_valid, isq.wb1_prd, prs1[i]);
            wake2[i] = valid[i] && is_reg2[i] &&
                       wb_hit(isq.wb0_valid, isq.wb0_prd, isq.wb1_valid, isq.wb1_prd, prs2[i]);
        end
    end

    assign ready = valid & ~busy1 & ~busy2;

    isq_age_sel #(
        .DEPTH(DEPTH)
    ) u_age_sel (
        .clock    (clock),
        .reset    (reset),
        .enq_fire (enq_fire),
        .enq_slot (enq_slot),
        .valid    (valid),
        .ready    (ready),
        .sel      (sel)
    );

    assign issue_valid = (|sel) && !isq.flush_valid;
    assign issue_fire  = issue_valid && isq.exu2intisq_issue_ready;

    // One-hot OR mux; sel is all-zero when nothing is ready
    always_comb begin
        mux_payload = '0;
        mux_robid   = '0;
        mux_prs1    = '0;
        mux_prs2    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                mux_payload = mux_payload | payload[i];
                mux_robid   = mux_robid   | robid[i];
                mux_prs1    = mux_prs1    | prs1[i];
                mux_prs2    = mux_prs2    | prs2[i];
            end
        end
    end

    assign isq.intisq_can_enq           = can_enq;
    assign isq.intisq2exu_issue_valid   = issue_valid;
    assign isq.intisq2exu_issue_payload = issue_valid ? mux_payload : '0;
    assign isq.intisq2exu_issue_robid   = issue_valid ? mux_robid   : '0;
    assign isq.intisq2exu_issue_prs1    = issue_valid ? mux_prs1    : '0;
    assign isq.intisq2exu_issue_prs2    = issue_valid ? mux_prs2    : '0;
    assign isq.intisq_count             = count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid   <= '0;
            is_reg1 <= '0;
            is_reg2 <= '0;
            busy1   <= '0;
            busy2   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                payload[i] <= '0;
                robid[i]   <= '0;
                prs1[i]    <= '0;
                prs2[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wake1[i]) busy1[i] <= 1'b0;
                if (wake2[i]) busy2[i] <= 1'b0;
                if (isq.flush_valid) begin
                    valid[i] <= 1'b0;
                end else if (issue_fire && sel[i]) begin
                    valid[i] <= 1'b0;
                end else if (enq_fire && enq_slot[i]) begin
                    valid[i]   <= 1'b1;
                    payload[i] <= isq.disp2intisq_enq_payload;
                    robid[i]   <= isq.disp2intisq_enq_robid;
                    prs1[i]    <= isq.disp2intisq_enq_prs1;
                    prs2[i]    <= isq.disp2intisq_enq_prs2;
                    is_reg1[i] <= isq.disp2intisq_enq_src1_is_reg;
                    is_reg2[i] <= isq.disp2intisq_enq_src2_is_reg;
                    busy1[i]   <= enq_busy1;
                    busy2[i]   <= enq_busy2;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (isq.flush_valid) begin
            count <= '0;
        end else if (enq_fire && !issue_fire) begin
            count <= count + CNT_W'(1);
        end else if (!enq_fire && issue_fire) begin
            count <= count - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_int_isq.sv
// Self-checking bench for int_isq.
// A reference model keeps the live micro-ops in a queue ordered by age. Each
// cycle the model's expected offer is the first entry in the queue whose
// sources are not busy.
module tb_int_isq;
    localparam int DEPTH = 8;
    localparam int PW    = 256;
    localparam int PREG  = 6;
    localparam int RW    = 7;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int_isq_if #(.PAYLOAD_W(PW), .PREG_W(PREG), .ROBID_W(RW), .COUNT_W(CW)) bus ();

    int_isq #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .PREG_W(PREG), .ROBID_W(RW)) dut (
        .clock (clock),
        .reset (reset),
        .isq   (bus)
    );

    typedef struct {
        logic [PW-1:0]   payload;
        logic [RW-1:0]   robid;
        logic [PREG-1:0] prs1, prs2;
        bit              r1, r2, b1, b2;
    } m_entry_t;

    typedef struct {
        bit              ev;
        logic [PW-1:0]   pl;
        logic [RW-1:0]   rid;
        logic [PREG-1:0] p1, p2;
        bit              r1, r2, s1, s2;
        bit              w0v, w1v;
        logic [PREG-1:0] w0p, w1p;
        bit              rdy, fl;
    } stim_t;

    m_entry_t q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_payload();
        logic [PW-1:0] p;
        for (int k = 0; k < PW / 32; k++) p[k*32 +: 32] = $urandom;
        return p;
    endfunction

    function automatic stim_t idle_stim(input bit rdy);
        stim_t s;
        s = '{ev: 0, pl: '0, rid: '0, p1: '0, p2: '0, r1: 0, r2: 0, s1: 0, s2: 0,
              w0v: 0, w1v: 0, w0p: '0, w1p: '0, rdy: rdy, fl: 0};
        return s;
    endfunction

    function automatic stim_t enq_stim(input int rid, input int p1, input bit s1,
                                       input int p2, input bit s2, input bit rdy);
        stim_t s;
        s     = idle_stim(rdy);
        s.ev  = 1;
        s.pl  = rand_payload();
        s.rid = RW'(rid);
        s.p1  = PREG'(p1);
        s.p2  = PREG'(p2);
        s.r1  = 1;
        s.r2  = 1;
        s.s1  = s1;
        s.s2  = s2;
        return s;
    endfunction

    function automatic bit hit(input stim_t s, input logic [PREG-1:0] p);
        return (s.w0v && s.w0p == p) || (s.w1v && s.w1p == p);
    endfunction

    task automatic drive(input stim_t s);
        bus.disp2intisq_enq_valid       = s.ev;
        bus.disp2intisq_enq_payload     = s.pl;
        bus.disp2intisq_enq_robid       = s.rid;
        bus.disp2intisq_enq_prs1        = s.p1;
        bus.disp2intisq_enq_prs2        = s.p2;
        bus.disp2intisq_enq_src1_is_reg = s.r1;
        bus.disp2intisq_enq_src2_is_reg = s.r2;
        bus.disp2intisq_enq_src1_state  = s.s1;
        bus.disp2intisq_enq_src2_state  = s.s2;
        bus.wb0_valid                   = s.w0v;
        bus.wb0_prd                     = s.w0p;
        bus.wb1_valid                   = s.w1v;
        bus.wb1_prd                     = s.w1p;
        bus.exu2intisq_issue_ready      = s.rdy;
        bus.flush_valid                 = s.fl;
    endtask

    // One clock cycle: drive at negedge, check outputs, advance model at posedge
    task automatic step(input stim_t s);
        int  sel;
        bit  exp_valid, can;
        @(negedge clock);
        drive(s);
        #1;
        sel = -1;
        foreach (q[i]) begin
            if (sel < 0 && !q[i].b1 && !q[i].b2) sel = i;
        end
        exp_valid = !s.fl && (sel >= 0);
        can       = !s.fl && (q.size() != DEPTH);
        check("issue_valid", bus.intisq2exu_issue_valid, exp_valid);
        check("count", bus.intisq_count, q.size());
        check("can_enq", bus.intisq_can_enq, can);
        if (exp_valid) begin
            check("issue_robid", bus.intisq2exu_issue_robid, q[sel].robid);
            check("issue_prs1", bus.intisq2exu_issue_prs1, q[sel].prs1);
            check("issue_prs2", bus.intisq2exu_issue_prs2, q[sel].prs2);
            check("issue_payload", bus.intisq2exu_issue_payload, q[sel].payload);
        end else begin
            check("idle_robid", bus.intisq2exu_issue_robid, 0);
            check("idle_payload", bus.intisq2exu_issue_payload, 0);
        end
        @(posedge clock);
        if (s.fl) begin
            q.delete();
        end else begin
            if (exp_valid && s.rdy) q.delete(sel);
            foreach (q[i]) begin
                if (q[i].r1 && hit(s, q[i].prs1)) q[i].b1 = 0;
                if (q[i].r2 && hit(s, q[i].prs2)) q[i].b2 = 0;
            end
            if (s.ev && can) begin
                m_entry_t e;
                e.payload = s.pl;
                e.robid   = s.rid;
                e.prs1    = s.p1;
                e.prs2    = s.p2;
                e.r1      = s.r1;
                e.r2      = s.r2;
                e.b1      = s.s1 && s.r1 && !hit(s, s.p1);
                e.b2      = s.s2 && s.r2 && !hit(s, s.p2);
                q.push_back(e);
            end
        end
    endtask

    initial begin
        stim_t s;

        // Reset values
        drive(idle_stim(0));
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_issue_valid", bus.intisq2exu_issue_valid, 0);
        check("rst_count", bus.intisq_count, 0);
        check("rst_can_enq", bus.intisq_can_enq, 1);
        @(negedge clock);
        reset = 1'b0;

        // Single ready entry: latency 1, then drains
        step(enq_stim(5, 1, 0, 2, 0, 1));
        step(idle_stim(1));
        step(idle_stim(1));

        // Younger ready entry bypasses an older busy one; wakeup then frees it
        step(enq_stim(1, 12, 1, 3, 0, 0));
        step(enq_stim(2, 4, 0, 5, 0, 0));
        step(idle_stim(1));
        s     = idle_stim(0);
        s.w0v = 1;
        s.w0p = 12;
        step(s);
        step(idle_stim(1));
        step(idle_stim(1));

        // Wakeup coincident with enqueue
        s     = enq_stim(3, 6, 0, 20, 1, 0);
        s.w1v = 1;
        s.w1p = 20;
        step(s);
        step(idle_stim(1));
        step(idle_stim(1));

        // Fill with busy entries, overflow attempt, then one issue with enq held
        for (int i = 0; i < DEPTH; i++) step(enq_stim(10 + i, 30 + i, 1, 40, 0, 0));
        step(enq_stim(99, 1, 0, 1, 0, 0));
        s     = enq_stim(98, 1, 0, 1, 0, 1);
        s.w0v = 1;
        s.w0p = 30;
        step(s);
        step(enq_stim(98, 1, 0, 1, 0, 1));
        step(enq_stim(97, 1, 0, 1, 0, 0));
        s    = idle_stim(0);
        s.fl = 1;
        step(s);

        // Back-pressure holds the oldest offer stable, then in-order drain
        step(enq_stim(7, 1, 0, 2, 0, 0));
        step(enq_stim(8, 1, 0, 2, 0, 0));
        step(enq_stim(9, 1, 0, 2, 0, 0));
        repeat (3) step(idle_stim(0));
        repeat (4) step(idle_stim(1));

        // Flush with entries present and enqueue requested
        for (int i = 0; i < 4; i++) step(enq_stim(20 + i, 50, 1, 1, 0, 0));
        s    = enq_stim(60, 1, 0, 1, 0, 1);
        s.fl = 1;
        step(s);
        step(idle_stim(1));

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) step(enq_stim(70 + i, 1, 0, 2, 0, 0));
        @(negedge clock);
        drive(idle_stim(0));
        #2;
        reset = 1'b1;
        #1;
        check("arst_issue_valid", bus.intisq2exu_issue_valid, 0);
        check("arst_count", bus.intisq_count, 0);
        check("arst_can_enq", bus.intisq_can_enq, 1);
        check("arst_robid", bus.intisq2exu_issue_robid, 0);
        q.delete();
        @(negedge clock);
        reset = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s     = idle_stim($urandom_range(0, 99) < 60);
            s.ev  = ($urandom_range(0, 99) < 60);
            s.pl  = rand_payload();
            s.rid = RW'($urandom);
            s.p1  = PREG'($urandom_range(0, 7));
            s.p2  = PREG'($urandom_range(0, 7));
            s.r1  = $urandom_range(0, 3) != 0;
            s.r2  = $urandom_range(0, 3) != 0;
            s.s1  = $urandom_range(0, 1);
            s.s2  = $urandom_range(0, 1);
            s.w0v = ($urandom_range(0, 99) < 30);
            s.w0p = PREG'($urandom_range(0, 7));
            s.w1v = ($urandom_range(0, 99) < 30);
            s.w1p = PREG'($urandom_range(0, 7));
            s.fl  = ($urandom_range(0, 99) < 2);
            step(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
